// File: rtl/image_scale_pkg.sv
// image_scale_pkg
// Shared definitions for the bilinear window fetcher and its coordinate clamp:
//   - fetch_state_t : FSM state encoding of bilinear_window_fetch
//   - FRAC_W        : width of the Q16.16 fractional part
//   - ONE_Q16       : 1.0 in Q16.16
//   - center_start  : start offset for pixel-centre alignment,
//                     max(step/2 - 0.5, 0) in Q16.16
package image_scale_pkg;

    localparam int          FRAC_W  = 16;
    localparam logic [31:0] ONE_Q16 = 32'h10000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPT    = 3'd3,
        ST_PRESENT = 3'd4,
        ST_DONE    = 3'd5
    } fetch_state_t;

    // The subtraction is unsigned, so the max(...,0) becomes a compare first.
    function automatic logic [31:0] center_start(input logic [31:0] step);
        logic [31:0] half;
        half = step >> 1;
        return (half > (ONE_Q16 >> 1)) ? (half - (ONE_Q16 >> 1)) : 32'd0;
    endfunction

endpackage

// File: rtl/scale_coord_clamp.sv
// scale_coord_clamp
// Decodes one Q16.16 source accumulator into the two neighbouring integer
// sample positions and the interpolation fraction, clamped to the image edge.
// Purely combinational; instantiated once per axis.
// Ports:
//   acc  in  32  Q16.16 source coordinate
//   c0   out 16  min(int, SIZE-1)
//   c1   out 16  min(c0+1, SIZE-1)
//   frac out 16  fractional part, forced to 0 at or beyond the last sample
module scale_coord_clamp
    import image_scale_pkg::*;
#(
    parameter int SIZE = 640
) (
    input  logic [31:0]       acc,
    output logic [15:0]       c0,
    output logic [15:0]       c1,
    output logic [FRAC_W-1:0] frac
);

    localparam logic [15:0] LAST = 16'(SIZE - 1);

    logic [15:0] int_part;

    always_comb begin
        int_part = acc[31:16];
        if (int_part >= LAST) begin
            // On or past the last sample both taps collapse onto the edge.
            c0   = LAST;
            c1   = LAST;
            frac = '0;
        end else begin
            // int_part < LAST here, so int_part+1 never passes the edge.
            c0   = int_part;
            c1   = int_part + 16'd1;
            frac = acc[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/bilinear_window_fetch.sv
// bilinear_window_fetch
// Walks an OUT_WIDTH x OUT_HEIGHT output raster, maps each output pixel to a
// Q16.16 source position, reads the 2x2 source neighbourhood from frame
// memory and presents it with the interpolation fractions.
//
// Build option: BILINEAR_FETCH_CENTER_EN defined selects pixel-centre
// alignment (start offset max(step/2 - 0.5, 0)); undefined selects corner
// alignment (start offset 0).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 frame request, ignored while busy
//   busy                  high in every state except IDLE
//   done                  one-cycle end-of-frame pulse
//   mem_rd_en/addr        frame memory read request
//   mem_rd_data           read data, valid the cycle after mem_rd_en
//   win_valid/win_ready   window handshake: a window transfers on a cycle
//                         where both are 1; while win_valid is 1 and
//                         win_ready is 0 all win_* outputs hold steady
//   win_pix               {p11, p10, p01, p00}
//   win_x_frac/win_y_frac interpolation fractions (Q0.16)
//   win_x_out/win_y_out   output pixel coordinate of the window
//   win_last              final pixel of the frame
//   dbg_state             current FSM state
module bilinear_window_fetch
    import image_scale_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int OUT_WIDTH  = 1280,
    parameter int OUT_HEIGHT = 960,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [4*DATA_WIDTH-1:0] win_pix,
    output logic [15:0]             win_x_frac,
    output logic [15:0]             win_y_frac,
    output logic [15:0]             win_x_out,
    output logic [15:0]             win_y_out,
    output logic                    win_last,
    output logic [2:0]              dbg_state
);

    localparam logic [31:0] STEP_X = 32'((IMG_WIDTH  * 65536) / OUT_WIDTH);
    localparam logic [31:0] STEP_Y = 32'((IMG_HEIGHT * 65536) / OUT_HEIGHT);
`ifdef BILINEAR_FETCH_CENTER_EN
    localparam logic [31:0] START_X = center_start(STEP_X);
    localparam logic [31:0] START_Y = center_start(STEP_Y);
`else
    localparam logic [31:0] START_X = 32'd0;
    localparam logic [31:0] START_Y = 32'd0;
`endif
    localparam logic [15:0] LAST_X = 16'(OUT_WIDTH - 1);
    localparam logic [15:0] LAST_Y = 16'(OUT_HEIGHT - 1);

    fetch_state_t state;
    logic [31:0]  acc_x, acc_y;
    logic [15:0]  x_out, y_out;
    logic [15:0]  cx0, cx1, cy0, cy1, fx, fy;
    logic [15:0]  x0_q, x1_q, y0_q, y1_q;
    logic [1:0]   rd_idx;
    logic [1:0]   cap_idx;
    logic         cap_en;

    scale_coord_clamp #(.SIZE(IMG_WIDTH)) u_clamp_x (
        .acc  (acc_x),
        .c0   (cx0),
        .c1   (cx1),
        .frac (fx)
    );

    scale_coord_clamp #(.SIZE(IMG_HEIGHT)) u_clamp_y (
        .acc  (acc_y),
        .c0   (cy0),
        .c1   (cy1),
        .frac (fy)
    );

    function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [15:0] row,
                                                       input logic [15:0] col);
        logic [31:0] lin;
        lin = 32'(row) * 32'(IMG_WIDTH) + 32'(col);
        return lin[ADDR_WIDTH-1:0];
    endfunction

    assign busy      = (state != ST_IDLE);
    assign win_x_out = x_out;
    assign win_y_out = y_out;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc_x       <= '0;
            acc_y       <= '0;
            x_out       <= '0;
            y_out       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            rd_idx      <= '0;
            cap_idx     <= '0;
            cap_en      <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            win_pix     <= '0;
            win_x_frac  <= '0;
            win_y_frac  <= '0;
            win_valid   <= 1'b0;
            win_last    <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Memory answers one cycle after the request, so the slot index
            // of each read travels one cycle behind it.
            cap_en  <= mem_rd_en;
            cap_idx <= rd_idx;
            if (cap_en) begin
                win_pix[int'(cap_idx)*DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data;
            end

            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    x_out <= '0;
                    y_out <= '0;
                    if (start) begin
                        acc_x <= START_X;
                        acc_y <= START_Y;
                        state <= ST_CALC;
                    end else begin
                        acc_x <= '0;
                        acc_y <= '0;
                    end
                end

                ST_CALC: begin
                    x0_q        <= cx0;
                    x1_q        <= cx1;
                    y0_q        <= cy0;
                    y1_q        <= cy1;
                    win_x_frac  <= fx;
                    win_y_frac  <= fy;
                    mem_rd_en   <= 1'b1;
                    mem_rd_addr <= pix_addr(cy0, cx0);
                    rd_idx      <= 2'd0;
                    state       <= ST_READ;
                end

                ST_READ: begin
                    // rd_idx names the read on the bus this cycle; set up the next.
                    case (rd_idx)
                        2'd0:    mem_rd_addr <= pix_addr(y0_q, x1_q);
                        2'd1:    mem_rd_addr <= pix_addr(y1_q, x0_q);
                        default: mem_rd_addr <= pix_addr(y1_q, x1_q);
                    endcase
                    if (rd_idx == 2'd3) begin
                        mem_rd_en   <= 1'b0;
                        mem_rd_addr <= mem_rd_addr;
                        state       <= ST_CAPT;
                    end else begin
                        rd_idx <= rd_idx + 2'd1;
                    end
                end

                ST_CAPT: begin
                    win_valid <= 1'b1;
                    win_last  <= (x_out == LAST_X) && (y_out == LAST_Y);
                    state     <= ST_PRESENT;
                end

                ST_PRESENT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        win_last  <= 1'b0;
                        if (x_out == LAST_X) begin
                            x_out <= '0;
                            acc_x <= START_X;
                            if (y_out == LAST_Y) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                y_out <= y_out + 16'd1;
                                acc_y <= acc_y + STEP_Y;
                                state <= ST_CALC;
                            end
                        end else begin
                            x_out <= x_out + 16'd1;
                            acc_x <= acc_x + STEP_X;
                            state <= ST_CALC;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
